gpio_word_receiver: RTL and testbench
=====================================

GPIO_WORD_RECEIVER -- requirements
Module: gpio_word_receiver

Purpose: Pulpino-side consumer of the GPIO byte handshake. Deserialises bytes into 32-bit words with valid/ready output.

Interface
REQ-001 clk  in  1  — single clock; all flops on rising edge.
REQ-002 rst_n  in  1  — reset, asynchronous assert, active-low.
REQ-003 gpio_data_i  in  8  — byte presented by the IO side; stable before io_turn_i changes.
REQ-004 io_turn_i  in  2  — IO-side turn token; a change means a new byte is present.
REQ-005 io_done_i  in  1  — IO side signals end of transfer (level).
REQ-006 pulpino_turn_o  out  2  — acknowledge token; equals io_turn_i once the byte is consumed.
REQ-007 word_o  out  32  — assembled word, little-endian (byte k in bits [8k+7:8k]).
REQ-008 word_bytes_o  out  3  — valid byte count in word_o, 0..4.
REQ-009 word_last_o  out  1  — word closes the transfer.
REQ-010 word_valid_o  out  1  — output holding register is full.
REQ-011 word_ready_i  in  1  — consumer accepts; transfer occurs when valid && ready.

Function
REQ-012 Synchronisers: io_turn_i and io_done_i SHALL each pass through a 2-flop synchroniser; gpio_data_i is sampled unsynchronised at accept time.
REQ-013 New-byte detection: pending = (sync_turn != pulpino_turn_o).
REQ-014 State RECV: on pending, the block SHALL accept the byte.
  - Write gpio_data_i into lane byte_cnt.
  - Increment byte_cnt (2 bits, wraps 3->0).
  - Register pulpino_turn_o <= sync_turn at the same edge.
REQ-015 Latency: pulpino_turn_o SHALL update exactly 3 clk edges after io_turn_i changes (2 sync + 1 accept), absent stall.
REQ-016 Only one byte per pending event; pulpino_turn_o is never updated without an accept.
REQ-017 Word completion: accepting the 4th byte (byte_cnt==3) SHALL load the holding register in the same edge.
  - word_bytes_o=4, word_last_o=0, word_valid_o=1.
  - Clear assembly lanes.
REQ-018 Stall: if the 4th byte is pending while word_valid_o=1 and not (word_ready_i), the block SHALL NOT accept it.
  - Enter state HOLD; pulpino_turn_o unchanged.
  - No byte is ever dropped or overwritten.
REQ-019 HOLD -> RECV on the edge where valid&&ready; the pending byte SHALL be accepted on that same edge, reloading the holding register (back-to-back, no bubble).
REQ-020 Bytes 1–3 of a word are accepted regardless of holding-register state.
REQ-021 Done: on a synchronised io_done_i rising edge with no pending token, the block SHALL emit a closing word.
  - word_bytes_o = byte_cnt (0..3), unused lanes zero, word_last_o=1.
  - byte_cnt and lanes are cleared.
REQ-022 Done with empty assembly SHALL emit word_bytes_o=0, word_o=0, word_last_o=1; exactly one last word per transfer.
REQ-023 Done when holding is full: the closing word waits in state FLUSH until valid&&ready, then loads on that edge.
REQ-024 Done with a pending token: the byte is accepted first; the done edge is serviced on a later cycle.
  - If that byte completes a word, the full word is emitted first, then a bytes=0 last word.
REQ-025 After a closing word, io_done_i must deassert (synchronised) before a new done edge is recognised; bytes keep being accepted meanwhile.
REQ-026 word_valid_o SHALL fall on the edge of valid&&ready unless reloaded in the same edge.
REQ-027 States: RECV, HOLD, FLUSH; encoding is free; no other reachable state.

Reset
REQ-028 On rst_n low, immediately and asynchronously:
  - pulpino_turn_o=0, word_o=0, word_bytes_o=0, word_last_o=0, word_valid_o=0.
  - byte_cnt=0, synchronisers=0, done-edge flag=0, state=RECV.
REQ-029 Reset mid-word SHALL discard partial bytes and any unaccepted holding word.
REQ-030 After reset release, a nonzero io_turn_i is treated as pending.

Verification
REQ-031 Bytes 0x11,0x22,0x33,0x44 with tokens 1,2,3,0, ready=1:
  - word_o=0x44332211, bytes=4, last=0.
  - Each ack lags its token by 3 cycles.
REQ-032 Backpressure:
  - ready=0, send 8 bytes -> first word held; 8th byte not acked (pulpino_turn_o frozen).
  - ready=1 -> first word taken and second word loaded on the same edge; 8th ack follows.
REQ-033 Bytes 0xAA,0xBB then done rising -> word_o=0x0000BBAA, bytes=2, last=1.
REQ-034 4 bytes then done (word consumed) -> full word, then word_o=0, bytes=0, last=1.
REQ-035 Done while holding is full and ready=0:
  - Closing word is emitted only after the handshake.
  - The held word is neither corrupted nor duplicated.
REQ-036 Assert rst_n low after 2 bytes:
  - All outputs 0 asynchronously.
  - After release, 4 new bytes form a clean word with no stale lanes.

Source files
------------

// File: rtl/gpio_word_receiver.sv
// Receives bytes over the two-bit turn-token handshake, packs them little-endian
// into 32-bit words and presents them through a single valid/ready holding register.
module gpio_word_receiver (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  gpio_data_i,
  input  logic [1:0]  io_turn_i,
  input  logic        io_done_i,
  output logic [1:0]  pulpino_turn_o,
  output logic [31:0] word_o,
  output logic [2:0]  word_bytes_o,
  output logic        word_last_o,
  output logic        word_valid_o,
  input  logic        word_ready_i
);

  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] ST_RECV  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]        turn_sync_p0, turn_sync_p1;
  logic              done_sync_p0, done_sync_p1, done_sync_p2;
  logic              done_flag;
  logic [1:0]        state, state_n;
  logic [1:0]        byte_cnt;
  logic [DATA_W-1:0] lane0, lane1, lane2;

  logic pending;
  logic done_rise;
  logic take;
  logic can_load;
  logic accept;
  logic load_full;
  logic load_close;

  // ---- synchroniser stages p0/p1; p2 of done is the edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      turn_sync_p0 <= '0;
      turn_sync_p1 <= '0;
      done_sync_p0 <= 1'b0;
      done_sync_p1 <= 1'b0;
      done_sync_p2 <= 1'b0;
    end else begin
      turn_sync_p0 <= io_turn_i;
      turn_sync_p1 <= turn_sync_p0;
      done_sync_p0 <= io_done_i;
      done_sync_p1 <= done_sync_p0;
      done_sync_p2 <= done_sync_p1;
    end
  end

  assign pending   = (turn_sync_p1 != pulpino_turn_o);
  assign done_rise = done_sync_p1 & ~done_sync_p2;
  assign take      = word_valid_o & word_ready_i;
  assign can_load  = ~word_valid_o | word_ready_i;

  // A pending byte always wins over a pending done so no byte is lost at the tail.
  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    load_full  = 1'b0;
    load_close = 1'b0;
    case (state)
      ST_RECV: begin
        if (pending) begin
          if (byte_cnt != 2'd3) begin
            accept = 1'b1;
          end else if (can_load) begin
            accept    = 1'b1;
            load_full = 1'b1;
          end else begin
            state_n = ST_HOLD;
          end
        end else if (done_flag) begin
          if (can_load) begin
            load_close = 1'b1;
          end else begin
            state_n = ST_FLUSH;
          end
        end
      end
      ST_HOLD: begin
        if (!pending) begin
          state_n = ST_RECV;
        end else if (take) begin
          accept    = 1'b1;
          load_full = 1'b1;
          state_n   = ST_RECV;
        end
      end
      ST_FLUSH: begin
        if (take) begin
          load_close = 1'b1;
          state_n    = ST_RECV;
        end
      end
      default: state_n = ST_RECV;
    endcase
  end

  // ---- accept / assembly stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_RECV;
      pulpino_turn_o <= '0;
      byte_cnt       <= '0;
      done_flag      <= 1'b0;
      lane0          <= '0;
      lane1          <= '0;
      lane2          <= '0;
    end else begin
      state     <= state_n;
      done_flag <= (done_flag & ~load_close) | done_rise;
      if (accept) begin
        pulpino_turn_o <= turn_sync_p1;
        byte_cnt       <= byte_cnt + 2'd1;
      end
      if (load_full || load_close) begin
        lane0 <= '0;
        lane1 <= '0;
        lane2 <= '0;
        if (load_close) byte_cnt <= '0;
      end else if (accept) begin
        case (byte_cnt)
          2'd0:    lane0 <= gpio_data_i;
          2'd1:    lane1 <= gpio_data_i;
          2'd2:    lane2 <= gpio_data_i;
          default: ;
        endcase
      end
    end
  end

  // ---- output holding register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_o       <= '0;
      word_bytes_o <= '0;
      word_last_o  <= 1'b0;
      word_valid_o <= 1'b0;
    end else begin
      if (load_full) begin
        word_o       <= {gpio_data_i, lane2, lane1, lane0};
        word_bytes_o <= 3'd4;
        word_last_o  <= 1'b0;
        word_valid_o <= 1'b1;
      end else if (load_close) begin
        word_o       <= {8'h00, lane2, lane1, lane0};
        word_bytes_o <= {1'b0, byte_cnt};
        word_last_o  <= 1'b1;
        word_valid_o <= 1'b1;
      end else if (take) begin
        word_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gpio_word_receiver.sv
// Scoreboard bench for gpio_word_receiver: a byte-level model pushes expected words,
// a negedge monitor pops and compares on every valid/ready transfer.
module tb_gpio_word_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  gpio_data = '0;
  logic [1:0]  io_turn = '0;
  logic        io_done = 1'b0;
  logic        word_ready = 1'b0;
  logic [1:0]  pulpino_turn;
  logic [31:0] word;
  logic [2:0]  word_bytes;
  logic        word_last;
  logic        word_valid;

  int checks = 0;
  int errors = 0;

  logic [35:0] exp_q[$];
  logic [7:0]  m_lane[4];
  int          m_cnt = 0;

  gpio_word_receiver dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .gpio_data_i    (gpio_data),
    .io_turn_i      (io_turn),
    .io_done_i      (io_done),
    .pulpino_turn_o (pulpino_turn),
    .word_o         (word),
    .word_bytes_o   (word_bytes),
    .word_last_o    (word_last),
    .word_valid_o   (word_valid),
    .word_ready_i   (word_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_cnt = 0;
    for (int i = 0; i < 4; i++) m_lane[i] = 8'h00;
  endfunction

  function automatic void model_byte(input logic [7:0] d);
    m_lane[m_cnt] = d;
    m_cnt++;
    if (m_cnt == 4) begin
      exp_q.push_back({m_lane[3], m_lane[2], m_lane[1], m_lane[0], 3'd4, 1'b0});
      model_clear();
    end
  endfunction

  function automatic void model_done();
    logic [2:0] nb;
    nb = 3'(m_cnt);
    exp_q.push_back({m_lane[3], m_lane[2], m_lane[1], m_lane[0], nb, 1'b1});
    model_clear();
  endfunction

  // Inputs change at posedge+2, so ready seen here holds through the next edge.
  always @(negedge clk) begin
    if (rst_n && word_valid && word_ready) begin
      chk("sb_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        logic [35:0] e;
        e = exp_q.pop_front();
        chk("word", 64'(word), 64'(e[35:4]));
        chk("bytes", 64'(word_bytes), 64'(e[3:1]));
        chk("last", 64'(word_last), 64'(e[0]));
      end
    end
  end

  task automatic wait_ack(output int n);
    n = 0;
    while (pulpino_turn != io_turn && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ack", 64'(pulpino_turn), 64'(io_turn));
  endtask

  task automatic drive_byte(input logic [7:0] d);
    @(posedge clk);
    #2;
    gpio_data = d;
    io_turn   = io_turn + 2'd1;
    model_byte(d);
  endtask

  task automatic send_byte(input logic [7:0] d, input int exp_lat);
    int n;
    drive_byte(d);
    wait_ack(n);
    if (exp_lat > 0) chk("ack_lat", 64'(n), 64'(exp_lat));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
  endtask

  task automatic pulse_done();
    @(posedge clk);
    #2;
    io_done = 1'b1;
    model_done();
  endtask

  task automatic drop_done();
    @(posedge clk);
    #2;
    io_done = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int n;
    logic [1:0] frozen;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(word_valid), 64'd0);
    chk("rst_turn", 64'(pulpino_turn), 64'd0);
    chk("rst_word", 64'(word), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    word_ready = 1'b1;

    // basic word, tokens 1,2,3,0, each ack 3 edges behind its token
    send_byte(8'h11, 3);
    send_byte(8'h22, 3);
    send_byte(8'h33, 3);
    send_byte(8'h44, 3);
    drain();

    // random full words with ready high
    for (int w = 0; w < 3; w++)
      for (int b = 0; b < 4; b++) send_byte(8'($urandom_range(0, 255)), 3);
    drain();

    // backpressure: eight bytes with ready low, the 8th must stall
    @(posedge clk);
    #2;
    word_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(8'(8'hA0 + i), 0);
    frozen = io_turn;
    drive_byte(8'hA7);
    repeat (10) @(posedge clk);
    #2;
    chk("turn_frozen", 64'(pulpino_turn), 64'(frozen));
    chk("held_valid", 64'(word_valid), 64'd1);
    chk("held_word", 64'(word), 64'h A3A2A1A0);
    word_ready = 1'b1;
    wait_ack(n);
    chk("hold_ack_lat", 64'(n), 64'd1);
    chk("reload_word", 64'(word), 64'hA7A6A5A4);
    drain();

    // partial word closed by done
    send_byte(8'hAA, 3);
    send_byte(8'hBB, 3);
    pulse_done();
    drain();
    drop_done();

    // three bytes then done
    send_byte(8'h01, 3);
    send_byte(8'h02, 3);
    send_byte(8'h03, 3);
    pulse_done();
    drain();
    drop_done();

    // full word then done: full word, then an empty last word
    send_byte(8'hC0, 3);
    send_byte(8'hC1, 3);
    send_byte(8'hC2, 3);
    send_byte(8'hC3, 3);
    pulse_done();
    drain();
    drop_done();

    // done while holding register is full and ready low
    @(posedge clk);
    #2;
    word_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'(8'hD0 + i), 0);
    pulse_done();
    repeat (10) @(posedge clk);
    #2;
    chk("flush_word", 64'(word), 64'hD3D2D1D0);
    chk("flush_last", 64'(word_last), 64'd0);
    chk("flush_valid", 64'(word_valid), 64'd1);
    word_ready = 1'b1;
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("no_dup_valid", 64'(word_valid), 64'd0);
    drop_done();

    // reset mid-word
    send_byte(8'hE0, 3);
    send_byte(8'hE1, 3);
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    io_turn = 2'd0;
    #1;
    chk("arst_turn", 64'(pulpino_turn), 64'd0);
    chk("arst_word", 64'(word), 64'd0);
    chk("arst_bytes", 64'(word_bytes), 64'd0);
    chk("arst_last", 64'(word_last), 64'd0);
    chk("arst_valid", 64'(word_valid), 64'd0);
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    send_byte(8'h5A, 3);
    send_byte(8'h6B, 3);
    send_byte(8'h7C, 3);
    send_byte(8'h8D, 3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
